// File: rtl/rggen_rtl_pkg.sv
// Shared types and limits for the rggen bit-field library.
package rggen_rtl_pkg;

    // Which side (software or hardware) sets a write-set/clear field.
    typedef enum logic {
        RGGEN_SET_MODE   = 1'b0,
        RGGEN_CLEAR_MODE = 1'b1
    } rggen_rwsc_mode;

    localparam int RGGEN_MAX_EVENT_SOURCES = 8;

endpackage

// File: rtl/rggen_register_if.sv
// Register-bus view seen by one bit field: a single access strobe plus write payload and read return.
interface rggen_register_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  valid;
    logic                  write;
    logic [DATA_WIDTH-1:0] write_data;
    logic [DATA_WIDTH-1:0] write_mask;
    logic [DATA_WIDTH-1:0] read_data;
    logic [DATA_WIDTH-1:0] value;

    // valid marks a one-cycle access; write selects write (1) or read (0).
    modport master (
        output valid,
        output write,
        output write_data,
        output write_mask,
        input  read_data,
        input  value
    );

    modport data (
        input  valid,
        input  write,
        input  write_data,
        input  write_mask,
        output read_data,
        output value
    );
endinterface

// File: rtl/rggen_event_edge_detector.sv
// Optional rising-edge detector for one hardware event vector; pass-through when disabled.
module rggen_event_edge_detector #(
    parameter int WIDTH  = 1,
    parameter bit ENABLE = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_event,
    output logic [WIDTH-1:0] o_event
);

    if (ENABLE) begin : g_edge
        logic [WIDTH-1:0] prev_q;

        // History resets to zero so an input already high after reset counts as an edge.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                prev_q <= '0;
            end else begin
                prev_q <= i_event;
            end
        end

        assign o_event = i_event & ~prev_q;
    end else begin : g_level
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst_n;
        assign o_event        = i_event;
    end

endmodule

// File: rtl/rggen_bit_field_rwsc_event.sv
// Multi-source status/interrupt bit field with software set/clear, optional clear-on-read and sticky overflow.
module rggen_bit_field_rwsc_event
    import rggen_rtl_pkg::*;
#(
    parameter rggen_rwsc_mode   MODE            = RGGEN_SET_MODE,
    parameter bit               SET_CLEAR_VALUE = 1'b1,
    parameter int               MSB             = 0,
    parameter int               LSB             = 0,
    parameter logic [MSB-LSB:0] INITIAL_VALUE   = '0,
    parameter int               SOURCES         = 1,
    parameter bit               EDGE_DETECT     = 1'b0,
    parameter bit               READ_CLEAR      = 1'b0,
    parameter bit               CLEAR_PRIORITY  = 1'b0
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [SOURCES*(MSB-LSB+1)-1:0]   i_event,
    rggen_register_if.data                   register_if,
    output logic [MSB-LSB:0]                 o_value,
    output logic [MSB-LSB:0]                 o_overflow,
    output logic                             o_any
);

    localparam int W = MSB - LSB + 1;

    if (READ_CLEAR && (MODE == RGGEN_SET_MODE)) begin : g_illegal_read_clear
        $error("rggen_bit_field_rwsc_event: READ_CLEAR needs RGGEN_CLEAR_MODE");
    end
    if ((SOURCES < 1) || (SOURCES > RGGEN_MAX_EVENT_SOURCES)) begin : g_illegal_sources
        $error("rggen_bit_field_rwsc_event: SOURCES must be 1..%0d", RGGEN_MAX_EVENT_SOURCES);
    end

    function automatic logic [W-1:0] calc_sw(
        input logic         wr,
        input logic [W-1:0] data,
        input logic [W-1:0] mask
    );
        if (!wr) begin
            return '0;
        end
        return mask & (SET_CLEAR_VALUE ? data : ~data);
    endfunction

    function automatic logic [W-1:0] calc_set(
        input logic [W-1:0] hw,
        input logic [W-1:0] sw
    );
        return (MODE == RGGEN_SET_MODE) ? sw : hw;
    endfunction

    function automatic logic [W-1:0] calc_clr(
        input logic [W-1:0] hw,
        input logic [W-1:0] sw,
        input logic         rd
    );
        if (MODE == RGGEN_SET_MODE) begin
            return hw;
        end
        return sw | {W{READ_CLEAR && rd}};
    endfunction

    function automatic logic [W-1:0] calc_next_value(
        input logic [W-1:0] set,
        input logic [W-1:0] clr,
        input logic [W-1:0] value
    );
        if (CLEAR_PRIORITY) begin
            return (set | value) & ~clr;
        end
        return set | (value & ~clr);
    endfunction

    // Overflow sticks until the bit is cleared by a clear that no set accompanies.
    function automatic logic [W-1:0] calc_next_overflow(
        input logic [W-1:0] set,
        input logic [W-1:0] clr,
        input logic [W-1:0] value,
        input logic [W-1:0] overflow
    );
        return (overflow | (set & value)) & ~(clr & ~set);
    endfunction

    logic [W-1:0] ev_src [SOURCES];
    logic [W-1:0] hw_event;
    logic [W-1:0] sw_event;
    logic [W-1:0] set_vec;
    logic [W-1:0] clr_vec;
    logic         write_access;
    logic         read_access;
    logic [W-1:0] value_q;
    logic [W-1:0] value_d;
    logic [W-1:0] overflow_q;
    logic [W-1:0] overflow_d;

    for (genvar s = 0; s < SOURCES; s++) begin : g_source
        rggen_event_edge_detector #(
            .WIDTH  (W),
            .ENABLE (EDGE_DETECT)
        ) u_edge (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_event (i_event[s*W +: W]),
            .o_event (ev_src[s])
        );
    end

    assign write_access = register_if.valid && register_if.write;
    assign read_access  = register_if.valid && !register_if.write;

    always_comb begin
        hw_event = '0;
        for (int s = 0; s < SOURCES; s++) begin
            hw_event = hw_event | ev_src[s];
        end
    end

    always_comb begin
        sw_event   = calc_sw(write_access,
                             register_if.write_data[MSB:LSB],
                             register_if.write_mask[MSB:LSB]);
        set_vec    = calc_set(hw_event, sw_event);
        clr_vec    = calc_clr(hw_event, sw_event, read_access);
        value_d    = calc_next_value(set_vec, clr_vec, value_q);
        overflow_d = calc_next_overflow(set_vec, clr_vec, value_q, overflow_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q    <= INITIAL_VALUE;
            overflow_q <= '0;
        end else begin
            value_q    <= value_d;
            overflow_q <= overflow_d;
        end
    end

    // Reads return the pre-update contents, so a clear-on-read still sees the old value.
    assign register_if.value[MSB:LSB]     = value_q;
    assign register_if.read_data[MSB:LSB] = value_q;

    assign o_value    = value_q;
    assign o_overflow = overflow_q;
    assign o_any      = |value_q;

endmodule

// File: tb/tb_rggen_bit_field_rwsc_event.sv
// Four differently configured fields share one bus and event stream, checked against a per-bit model.
module tb_rggen_bit_field_rwsc_event;
    import rggen_rtl_pkg::*;

    localparam int N = 4;
    // Per-instance configuration, bit k belongs to instance k.
    localparam logic [3:0]  CFG_CLRMODE = 4'b0011;
    localparam logic [3:0]  CFG_SCV     = 4'b0011;
    localparam logic [3:0]  CFG_EDGE    = 4'b1010;
    localparam logic [3:0]  CFG_RC      = 4'b0011;
    localparam logic [3:0]  CFG_CP      = 4'b0110;
    localparam logic [31:0] CFG_INIT    = {8'h81, 8'h00, 8'h00, 8'h81};

    logic        clk;
    logic        rst_n;
    logic [15:0] bus_event;
    logic        bus_valid;
    logic        bus_write;
    logic [7:0]  bus_wdata;
    logic [7:0]  bus_wmask;

    logic [7:0] dut_val [N];
    logic [7:0] dut_ovf [N];
    logic       dut_any [N];
    logic [7:0] dut_rd  [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        rggen_register_if #(.DATA_WIDTH(8)) rif ();
        assign rif.valid      = bus_valid;
        assign rif.write      = bus_write;
        assign rif.write_data = bus_wdata;
        assign rif.write_mask = bus_wmask;
        assign dut_rd[g]      = rif.read_data;

        rggen_bit_field_rwsc_event #(
            .MODE            (CFG_CLRMODE[g] ? RGGEN_CLEAR_MODE : RGGEN_SET_MODE),
            .SET_CLEAR_VALUE (CFG_SCV[g]),
            .MSB             (7),
            .LSB             (0),
            .INITIAL_VALUE   (CFG_INIT[g*8 +: 8]),
            .SOURCES         (2),
            .EDGE_DETECT     (CFG_EDGE[g]),
            .READ_CLEAR      (CFG_RC[g]),
            .CLEAR_PRIORITY  (CFG_CP[g])
        ) u_dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .i_event     (bus_event),
            .register_if (rif),
            .o_value     (dut_val[g]),
            .o_overflow  (dut_ovf[g]),
            .o_any       (dut_any[g])
        );
    end

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // reference model and scoreboard
    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  m_val  [N];
    logic [7:0]  m_ovf  [N];
    logic [15:0] m_prev [N];
    logic [63:0] exp_q[$];     // {ovf,val} per instance, 16 bits each
    logic [31:0] exp_rd_q[$];  // read_data per instance, 8 bits each

    task automatic chk(input string name, input int k, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %h expected %h at %0t", name, k, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_val[k]  = CFG_INIT[k*8 +: 8];
            m_ovf[k]  = 8'h00;
            m_prev[k] = 16'h0000;
        end
    endtask

    task automatic model_step(input logic [15:0] ev, input logic v, input logic w,
                              input logic [7:0] wd, input logic [7:0] wm);
        logic [63:0] e;
        logic [31:0] r;
        logic hw, sw, rc, set, clr, old;
        for (int k = 0; k < N; k++) begin
            r[k*8 +: 8] = m_val[k];
            for (int b = 0; b < 8; b++) begin
                hw = 1'b0;
                for (int s = 0; s < 2; s++) begin
                    if (CFG_EDGE[k]) begin
                        if (ev[s*8+b] && !m_prev[k][s*8+b]) hw = 1'b1;
                    end else if (ev[s*8+b]) begin
                        hw = 1'b1;
                    end
                end
                sw  = v && w && wm[b] && (wd[b] == CFG_SCV[k]);
                rc  = CFG_RC[k] && v && !w;
                set = CFG_CLRMODE[k] ? hw : sw;
                clr = CFG_CLRMODE[k] ? (sw || rc) : hw;
                old = m_val[k][b];
                if (set && clr)  m_val[k][b] = CFG_CP[k] ? 1'b0 : 1'b1;
                else if (set)    m_val[k][b] = 1'b1;
                else if (clr)    m_val[k][b] = 1'b0;
                if (set && old)        m_ovf[k][b] = 1'b1;
                else if (clr && !set)  m_ovf[k][b] = 1'b0;
            end
            m_prev[k] = ev;
            e[k*16 +: 16] = {m_ovf[k], m_val[k]};
        end
        if (v && !w) exp_rd_q.push_back(r);
        exp_q.push_back(e);
    endtask

    // driver tasks
    task automatic cycle(input logic [15:0] ev, input logic v, input logic w,
                         input logic [7:0] wd, input logic [7:0] wm);
        @(negedge clk);
        bus_event = ev;
        bus_valid = v;
        bus_write = w;
        bus_wdata = wd;
        bus_wmask = wm;
        model_step(ev, v, w, wd, wm);
    endtask

    task automatic zero_inputs();
        bus_event = '0;
        bus_valid = 1'b0;
        bus_write = 1'b0;
        bus_wdata = '0;
        bus_wmask = '0;
    endtask

    task automatic check_reset_state();
        for (int k = 0; k < N; k++) begin
            chk("reset_value", k, dut_val[k], CFG_INIT[k*8 +: 8]);
            chk("reset_overflow", k, dut_ovf[k], 8'h00);
            chk("reset_any", k, {7'd0, dut_any[k]}, {7'd0, |CFG_INIT[k*8 +: 8]});
        end
    endtask

    task automatic async_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        zero_inputs();
        model_reset();
        #1;
        check_reset_state();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // monitors
    always @(posedge clk) begin
        logic [63:0] e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            for (int k = 0; k < N; k++) begin
                chk("value", k, dut_val[k], e[k*16 +: 8]);
                chk("overflow", k, dut_ovf[k], e[k*16+8 +: 8]);
                chk("any", k, {7'd0, dut_any[k]}, {7'd0, |e[k*16 +: 8]});
            end
        end
    end

    always @(negedge clk) begin
        logic [31:0] r;
        #2;
        if (rst_n && bus_valid && !bus_write && exp_rd_q.size() > 0) begin
            r = exp_rd_q.pop_front();
            for (int k = 0; k < N; k++) begin
                chk("read_data", k, dut_rd[k], r[k*8 +: 8]);
            end
        end
    end

    // stimulus
    initial begin
        rst_n = 1'b0;
        zero_inputs();
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_state();
        rst_n = 1'b1;

        // two sources merge, software clear, overflow set and cleared
        cycle(16'h0000, 1'b1, 1'b0, 8'h00, 8'h00);
        cycle(16'h1001, 1'b0, 1'b0, 8'h00, 8'h00);
        settle();
        chk("merge_sources", 0, dut_val[0], 8'h11);
        cycle(16'h0000, 1'b1, 1'b1, 8'h01, 8'hFF);
        settle();
        chk("sw_clear", 0, dut_val[0], 8'h10);
        cycle(16'h0001, 1'b0, 1'b0, 8'h00, 8'h00);
        cycle(16'h0001, 1'b0, 1'b0, 8'h00, 8'h00);
        settle();
        chk("overflow_set_val", 0, dut_val[0], 8'h11);
        chk("overflow_set", 0, dut_ovf[0], 8'h01);
        cycle(16'h0000, 1'b1, 1'b1, 8'h01, 8'hFF);
        settle();
        chk("overflow_clr_val", 0, dut_val[0], 8'h10);
        chk("overflow_clr", 0, dut_ovf[0], 8'h00);
        cycle(16'h0000, 1'b1, 1'b1, 8'hFF, 8'h00);
        settle();
        chk("zero_mask", 0, dut_val[0], 8'h10);

        // clear-on-read, then read colliding with an event
        cycle(16'h3C00, 1'b0, 1'b0, 8'h00, 8'h00);
        cycle(16'h0000, 1'b1, 1'b0, 8'h00, 8'h00);
        settle();
        chk("read_clear", 0, dut_val[0], 8'h00);
        cycle(16'h3C00, 1'b0, 1'b0, 8'h00, 8'h00);
        cycle(16'h0002, 1'b1, 1'b0, 8'h00, 8'h00);
        settle();
        chk("read_vs_event_cp0", 0, dut_val[0], 8'h02);

        // edge detection: held input sets once, a new edge overflows
        cycle(16'h0000, 1'b1, 1'b0, 8'h00, 8'h00);
        repeat (5) cycle(16'h0001, 1'b0, 1'b0, 8'h00, 8'h00);
        settle();
        chk("edge_once_val", 1, {7'd0, dut_val[1][0]}, 8'h01);
        chk("edge_once_ovf", 1, {7'd0, dut_ovf[1][0]}, 8'h00);
        cycle(16'h0000, 1'b0, 1'b0, 8'h00, 8'h00);
        cycle(16'h0001, 1'b0, 1'b0, 8'h00, 8'h00);
        settle();
        chk("edge_again_ovf", 1, {7'd0, dut_ovf[1][0]}, 8'h01);

        // software set (write-0) against same-cycle hardware clear
        cycle(16'h0000, 1'b0, 1'b0, 8'h00, 8'h00);
        cycle(16'h0001, 1'b1, 1'b1, 8'hFE, 8'h0F);
        settle();
        chk("set_vs_clr_cp1", 2, {7'd0, dut_val[2][0]}, 8'h00);
        chk("set_vs_clr_cp0", 3, {7'd0, dut_val[3][0]}, 8'h01);

        // randomized traffic with an asynchronous reset in the middle
        for (int i = 0; i < 600; i++) begin
            logic [15:0] ev;
            int op;
            if (i == 300) async_reset();
            ev = 16'($urandom) & 16'($urandom);
            op = $urandom_range(0, 3);
            case (op)
                1:       cycle(ev, 1'b1, 1'b1, 8'($urandom), 8'($urandom));
                2:       cycle(ev, 1'b1, 1'b0, 8'($urandom), 8'($urandom));
                default: cycle(ev, 1'b0, 1'b0, 8'($urandom), 8'($urandom));
            endcase
        end

        @(negedge clk);
        zero_inputs();
        settle();
        n_tests++;
        if (exp_q.size() != 0 || exp_rd_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d state and %0d read entries left, expected 0",
                     exp_q.size(), exp_rd_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
